// File: rtl/reg_file.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : reg_file                                               |
// | Description : Y86-style register file, two combinational read ports, |
// |               two write-back ports (M wins on collision), saturating |
// |               commit counter.                                        |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module reg_file #(
    parameter int DATA_W = 64,
    parameter int NREG   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        d_srcA,
    input  logic [3:0]        d_srcB,
    output logic [DATA_W-1:0] d_rvalA,
    output logic [DATA_W-1:0] d_rvalB,
    input  logic [3:0]        W_dstE,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [3:0]        W_dstM,
    input  logic [DATA_W-1:0] W_valM,
    output logic [15:0]       wr_count
);

    localparam logic [3:0] c_RNONE = 4'hF;
    localparam logic [4:0] c_NREG  = 5'(NREG);

    logic [DATA_W-1:0] w_rf [NREG];
    logic              w_e_vld;
    logic              w_m_vld;
    logic              w_same;
    logic [1:0]        w_inc;
    logic [16:0]       w_sum;
    logic [15:0]       w_wr_count_d;
    logic [15:0]       r_wr_count_q;
    logic [DATA_W-1:0] w_rvalA;
    logic [DATA_W-1:0] w_rvalB;

    // IDs at or above NREG (including RNONE) have no storage and never commit.
    always_comb begin
        w_e_vld = (W_dstE != c_RNONE) && ({1'b0, W_dstE} < c_NREG);
        w_m_vld = (W_dstM != c_RNONE) && ({1'b0, W_dstM} < c_NREG);
        w_same  = w_e_vld && w_m_vld && (W_dstE == W_dstM);
    end

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            logic [DATA_W-1:0] r_rf_q;
            logic [DATA_W-1:0] w_rf_d;

            // M is applied last so it overrides E on a same-ID collision.
            always_comb begin
                w_rf_d = r_rf_q;
                if (w_e_vld && (W_dstE == 4'(gi))) begin
                    w_rf_d = W_valE;
                end
                if (w_m_vld && (W_dstM == 4'(gi))) begin
                    w_rf_d = W_valM;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rf_q <= '0;
                end else begin
                    r_rf_q <= w_rf_d;
                end
            end

            assign w_rf[gi] = r_rf_q;
        end
    endgenerate

    always_comb begin
        w_inc        = {1'b0, w_e_vld} + {1'b0, w_m_vld} - {1'b0, w_same};
        w_sum        = {1'b0, r_wr_count_q} + {15'b0, w_inc};
        w_wr_count_d = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_count_q <= '0;
        end else begin
            r_wr_count_q <= w_wr_count_d;
        end
    end

    // Reads are gated by rst so outputs are zero for the whole reset window.
    always_comb begin
        w_rvalA = '0;
        w_rvalB = '0;
        for (int i = 0; i < NREG; i++) begin
            if (d_srcA == 4'(i)) begin
                w_rvalA = w_rf[i];
            end
            if (d_srcB == 4'(i)) begin
                w_rvalB = w_rf[i];
            end
        end
        if (rst) begin
            w_rvalA = '0;
            w_rvalB = '0;
        end
    end

    assign d_rvalA  = w_rvalA;
    assign d_rvalB  = w_rvalB;
    assign wr_count = r_wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_reg_file                                            |
// | Description : Directed scoreboard bench for reg_file.                |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_reg_file;

    localparam int DATA_W = 64;
    localparam int NREG   = 15;

    logic              clk;
    logic              rst;
    logic [3:0]        d_srcA;
    logic [3:0]        d_srcB;
    logic [DATA_W-1:0] d_rvalA;
    logic [DATA_W-1:0] d_rvalB;
    logic [3:0]        W_dstE;
    logic [DATA_W-1:0] W_valE;
    logic [3:0]        W_dstM;
    logic [DATA_W-1:0] W_valM;
    logic [15:0]       wr_count;

    reg_file #(.DATA_W(DATA_W), .NREG(NREG)) dut (
        .clk     (clk),
        .rst     (rst),
        .d_srcA  (d_srcA),
        .d_srcB  (d_srcB),
        .d_rvalA (d_rvalA),
        .d_rvalB (d_rvalB),
        .W_dstE  (W_dstE),
        .W_valE  (W_valE),
        .W_dstM  (W_dstM),
        .W_valM  (W_valM),
        .wr_count(wr_count)
    );

    typedef struct {
        string             tag;
        logic [DATA_W-1:0] exp;
    } sb_t;

    sb_t               sb_q[$];
    int                n_checks;
    int                n_pass;
    logic [DATA_W-1:0] mdl [NREG];
    int                mdl_cnt;

    // Clock is pulsed on demand so reset can be exercised with no edge at all.
    task automatic tick();
        #4 clk = 1'b1;
        #5 clk = 1'b0;
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [DATA_W-1:0] v);
        sb_t e;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic check_next(input logic [DATA_W-1:0] obs);
        sb_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %h with no expected entry", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) begin
                n_pass++;
            end else begin
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic model_write(input logic [3:0] de, input logic [DATA_W-1:0] ve,
                               input logic [3:0] dm, input logic [DATA_W-1:0] vm);
        int inc;
        inc = 0;
        if (de != 4'hF) begin mdl[de] = ve; inc++; end
        if (dm != 4'hF) begin mdl[dm] = vm; inc++; end
        if (de != 4'hF && dm == de) inc--;
        mdl_cnt = (mdl_cnt + inc > 65535) ? 65535 : mdl_cnt + inc;
    endtask

    task automatic do_write(input logic [3:0] de, input logic [DATA_W-1:0] ve,
                            input logic [3:0] dm, input logic [DATA_W-1:0] vm);
        W_dstE = de; W_valE = ve; W_dstM = dm; W_valM = vm;
        tick();
        model_write(de, ve, dm, vm);
        W_dstE = 4'hF; W_dstM = 4'hF;
    endtask

    task automatic check_count(input string tag);
        expect_val(tag, DATA_W'(mdl_cnt));
        check_next(DATA_W'(wr_count));
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < NREG; i++) begin
            d_srcA = 4'(i);
            #1;
            expect_val(tag, mdl[i]);
            check_next(d_rvalA);
        end
    endtask

    initial begin
        logic [3:0]        de;
        logic [3:0]        dm;
        logic [DATA_W-1:0] ve;
        logic [DATA_W-1:0] vm;

        n_checks = 0;
        n_pass   = 0;
        mdl_cnt  = 0;
        for (int i = 0; i < NREG; i++) mdl[i] = '0;
        clk = 1'b0; rst = 1'b0;
        d_srcA = 4'd0; d_srcB = 4'd0;
        W_dstE = 4'hF; W_dstM = 4'hF; W_valE = '0; W_valM = '0;

        // Reset pulse with no clock edge, then sweep every read ID.
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        #2;
        for (int i = 0; i < 16; i++) begin
            d_srcA = 4'(i);
            #1;
            expect_val("reset_sweep", '0);
            check_next(d_rvalA);
        end
        check_count("reset_count");

        // Single E write; old value visible until the edge.
        d_srcA = 4'd3;
        W_dstE = 4'd3; W_valE = 64'h1122334455667788; W_dstM = 4'hF;
        #1;
        expect_val("single_pre_edge", '0);
        check_next(d_rvalA);
        do_write(4'd3, 64'h1122334455667788, 4'hF, '0);
        expect_val("single_write", 64'h1122334455667788);
        check_next(d_rvalA);
        expect_val("single_count", 64'd1);
        check_next(DATA_W'(wr_count));

        // Dual write to distinct IDs.
        do_write(4'd1, 64'd5, 4'd2, 64'd9);
        d_srcA = 4'd1; d_srcB = 4'd2;
        #1;
        expect_val("dual_reg1", 64'd5);
        check_next(d_rvalA);
        expect_val("dual_reg2", 64'd9);
        check_next(d_rvalB);
        expect_val("dual_count", 64'd3);
        check_next(DATA_W'(wr_count));

        // Same-ID collision: M wins, counts once.
        do_write(4'd4, 64'd100, 4'd4, 64'd200);
        d_srcB = 4'd4;
        #1;
        expect_val("collision_val", 64'd200);
        check_next(d_rvalB);
        expect_val("collision_count", 64'd4);
        check_next(DATA_W'(wr_count));

        // No bypass: read of reg5 during its write cycle stays at the old value.
        d_srcA = 4'd5;
        W_dstE = 4'd5; W_valE = 64'hDEAD;
        #1;
        expect_val("no_bypass", mdl[5]);
        check_next(d_rvalA);
        do_write(4'd5, 64'hDEAD, 4'hF, '0);

        // RNONE on both ports with random data.
        for (int k = 0; k < 10; k++) begin
            do_write(4'hF, {$urandom, $urandom}, 4'hF, {$urandom, $urandom});
        end
        check_all_regs("rnone_regs");
        check_count("rnone_count");
        d_srcA = 4'hF;
        #1;
        expect_val("rnone_read", '0);
        check_next(d_rvalA);

        // Random mixed writes against the model.
        for (int k = 0; k < 40; k++) begin
            de = 4'($urandom_range(0, 15));
            dm = (k % 5 == 0) ? de : 4'($urandom_range(0, 15));
            ve = {$urandom, $urandom};
            vm = {$urandom, $urandom};
            do_write(de, ve, dm, vm);
        end
        check_all_regs("random_regs");
        check_count("random_count");

        // Mid-operation reset with a write pending.
        do_write(4'd7, 64'hFF, 4'hF, '0);
        d_srcA = 4'd7;
        #1;
        expect_val("reg7_written", 64'hFF);
        check_next(d_rvalA);
        W_dstE = 4'd7; W_valE = 64'h123; W_dstM = 4'd8; W_valM = 64'h456;
        #1 rst = 1'b1;
        #1;
        expect_val("midrst_reg7", '0);
        check_next(d_rvalA);
        expect_val("midrst_count", '0);
        check_next(DATA_W'(wr_count));
        tick();
        expect_val("rst_held_write_ignored", '0);
        check_next(d_rvalA);
        rst = 1'b0;
        W_dstE = 4'hF; W_dstM = 4'hF;
        for (int i = 0; i < NREG; i++) mdl[i] = '0;
        mdl_cnt = 0;
        #1;
        check_all_regs("post_rst_regs");
        check_count("post_rst_count");

        // First edge after reset release commits.
        do_write(4'd7, 64'h55, 4'hF, '0);
        d_srcA = 4'd7;
        #1;
        expect_val("first_write_after_rst", 64'h55);
        check_next(d_rvalA);

        // Drive the counter into saturation with dual writes.
        for (int k = 0; k < 32770; k++) begin
            do_write(4'd0, DATA_W'(k), 4'd1, DATA_W'(k + 1));
        end
        expect_val("sat_count", 64'hFFFF);
        check_next(DATA_W'(wr_count));
        check_count("sat_model_count");
        do_write(4'd2, 64'd1, 4'd3, 64'd2);
        do_write(4'd6, 64'd3, 4'hF, '0);
        expect_val("sat_hold", 64'hFFFF);
        check_next(DATA_W'(wr_count));
        check_all_regs("final_regs");

        if (sb_q.size() != 0) begin
            n_checks++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
